// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in/parallel-out deserialiser with word framing and handshakes
module sipo_deser #(
    parameter int Insz     = 1,
    parameter int Outsz    = 32,
    parameter bit Msbfirst = 1'b1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             CLEAR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [Insz-1:0]  IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [Outsz-1:0] OUT,
    output logic             PARTIAL
);

    localparam int Depth = Outsz / Insz;
    localparam int CntW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Depth - 1);

    if ((Outsz % Insz) != 0 || Depth < 1) begin : g_bad_cfg
        $error("sipo_deser: Outsz must be a non-zero integer multiple of Insz");
    end

    logic [Outsz-1:0] sr_q, sr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Outsz-1:0] hold_q, hold_d;
    logic             out_valid_q, out_valid_d;

    logic [Outsz-1:0] sr_shift;
    logic             last_beat;
    logic             in_ready;
    logic             accept;
    logic             consume;

    // Shift register contents after absorbing the current beat, in the configured order.
    if (Depth == 1) begin : g_shift_single
        always_comb sr_shift = IN;
    end else if (Msbfirst) begin : g_shift_msb
        always_comb sr_shift = {sr_q[Outsz-Insz-1:0], IN};
    end else begin : g_shift_lsb
        always_comb sr_shift = {IN, sr_q[Outsz-1:Insz]};
    end

    // Handshake decode: only the final beat of a word waits on an unconsumed held word.
    always_comb begin
        last_beat = (cnt_q == LastCnt);
        in_ready  = !out_valid_q || OUT_READY || !last_beat;
        accept    = IN_VALID && in_ready && !CLEAR;
        consume   = out_valid_q && OUT_READY;
    end

    // Next-state: assembly, final-beat hand-off to the holding register, abort on CLEAR.
    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;

        if (consume) begin
            out_valid_d = 1'b0;
        end

        if (CLEAR) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (accept) begin
            sr_d = sr_shift;
            if (last_beat) begin
                cnt_d       = '0;
                hold_d      = sr_shift;
                out_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // State registers; reset discards any partial or held word immediately.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Outputs come straight from registered state, except the ready path from OUT_READY.
    always_comb begin
        IN_READY  = in_ready;
        OUT_VALID = out_valid_q;
        OUT       = hold_q;
        PARTIAL   = (cnt_q != '0);
    end

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - directed bench for sipo_deser with a beat-list reference model
module tb_sipo_deser;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // Group A: 1-bit beats; group B: 8-bit beats
    logic       a_clr = 0, a_iv = 0, a_in = 0, a_ordy = 1;
    logic       b_clr = 0, b_iv = 0, b_ordy = 1;
    logic [7:0] b_in = 0;

    logic d_rdy [5];
    logic d_ov  [5];
    logic d_part[5];
    logic [7:0]  o0, o1, o4;
    logic [31:0] o2, o3;
    logic [31:0] d_out[5];
    assign d_out[0] = {24'd0, o0};
    assign d_out[1] = {24'd0, o1};
    assign d_out[2] = o2;
    assign d_out[3] = o3;
    assign d_out[4] = {24'd0, o4};

    sipo_deser #(.Insz(1), .Outsz(8), .Msbfirst(1'b1)) u0 (
        .CLK(clk), .RSTN(rstn), .CLEAR(a_clr), .IN_VALID(a_iv), .IN_READY(d_rdy[0]),
        .IN(a_in), .OUT_VALID(d_ov[0]), .OUT_READY(a_ordy), .OUT(o0), .PARTIAL(d_part[0]));
    sipo_deser #(.Insz(1), .Outsz(8), .Msbfirst(1'b0)) u1 (
        .CLK(clk), .RSTN(rstn), .CLEAR(a_clr), .IN_VALID(a_iv), .IN_READY(d_rdy[1]),
        .IN(a_in), .OUT_VALID(d_ov[1]), .OUT_READY(a_ordy), .OUT(o1), .PARTIAL(d_part[1]));
    sipo_deser #(.Insz(8), .Outsz(32), .Msbfirst(1'b1)) u2 (
        .CLK(clk), .RSTN(rstn), .CLEAR(b_clr), .IN_VALID(b_iv), .IN_READY(d_rdy[2]),
        .IN(b_in), .OUT_VALID(d_ov[2]), .OUT_READY(b_ordy), .OUT(o2), .PARTIAL(d_part[2]));
    sipo_deser #(.Insz(8), .Outsz(32), .Msbfirst(1'b0)) u3 (
        .CLK(clk), .RSTN(rstn), .CLEAR(b_clr), .IN_VALID(b_iv), .IN_READY(d_rdy[3]),
        .IN(b_in), .OUT_VALID(d_ov[3]), .OUT_READY(b_ordy), .OUT(o3), .PARTIAL(d_part[3]));
    sipo_deser #(.Insz(8), .Outsz(8), .Msbfirst(1'b1)) u4 (
        .CLK(clk), .RSTN(rstn), .CLEAR(b_clr), .IN_VALID(b_iv), .IN_READY(d_rdy[4]),
        .IN(b_in), .OUT_VALID(d_ov[4]), .OUT_READY(b_ordy), .OUT(o4), .PARTIAL(d_part[4]));

    int P_IN [5] = '{1, 1, 8, 8, 8};
    int P_OUT[5] = '{8, 8, 32, 32, 8};
    bit P_MSB[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reference model: count of beats in the current word, word built slice by slice
    int          m_cnt [5] = '{0, 0, 0, 0, 0};
    logic [31:0] m_part[5] = '{0, 0, 0, 0, 0};
    logic [31:0] m_held[5] = '{0, 0, 0, 0, 0};
    bit          m_hv  [5] = '{0, 0, 0, 0, 0};
    bit          started = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_rdy(input int i, input bit ordy);
        return !m_hv[i] || ordy || (m_cnt[i] != P_OUT[i] / P_IN[i] - 1);
    endfunction

    task automatic m_step(input int i, input bit clr, input bit iv, input logic [31:0] din, input bit ordy);
        int depth = P_OUT[i] / P_IN[i];
        logic [31:0] mask = (32'd1 << P_IN[i]) - 32'd1;
        bit acc = iv && m_rdy(i, ordy) && !clr;
        int slot;
        if (m_hv[i] && ordy) m_hv[i] = 0;
        if (clr) begin
            m_cnt[i]  = 0;
            m_part[i] = 0;
        end else if (acc) begin
            slot = P_MSB[i] ? (depth - 1 - m_cnt[i]) : m_cnt[i];
            m_part[i] = m_part[i] | ((din & mask) << (slot * P_IN[i]));
            if (m_cnt[i] == depth - 1) begin
                m_held[i] = m_part[i];
                m_hv[i]   = 1;
                m_part[i] = 0;
                m_cnt[i]  = 0;
            end else begin
                m_cnt[i]++;
            end
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 5; i++) begin
                m_cnt[i] = 0; m_part[i] = 0; m_held[i] = 0; m_hv[i] = 0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (i < 2) m_step(i, a_clr, a_iv, {31'd0, a_in}, a_ordy);
                else       m_step(i, b_clr, b_iv, {24'd0, b_in}, b_ordy);
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("u%0d in_ready", i), {31'd0, d_rdy[i]},
                    {31'd0, m_rdy(i, (i < 2) ? a_ordy : b_ordy)});
                chk($sformatf("u%0d out_valid", i), {31'd0, d_ov[i]}, {31'd0, m_hv[i]});
                chk($sformatf("u%0d out", i), d_out[i], m_held[i]);
                chk($sformatf("u%0d partial", i), {31'd0, d_part[i]}, {31'd0, m_cnt[i] != 0});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic b);
        a_iv = 1; a_in = b;
        step();
    endtask

    task automatic send_b(input logic [7:0] v);
        int n = 0;
        b_iv = 1; b_in = v;
        while (!d_rdy[2] && n < 16) begin
            step();
            n++;
        end
        chk("send_b wait bound", {31'd0, n < 16}, 32'd1);
        step();
    endtask

    logic [7:0] bits1;

    initial begin
        bits1 = 8'b1011_0010;
        step();
        #2 rstn = 1;
        chk("reset out_valid", {31'd0, d_ov[2]}, 32'd0);
        chk("reset in_ready", {31'd0, d_rdy[2]}, 32'd1);

        // Bit order, both directions
        for (int k = 7; k >= 0; k--) begin
            send_a(bits1[k]);
            if (k == 7) chk("t1 partial after beat1", {31'd0, d_part[0]}, 32'd1);
        end
        a_iv = 0;
        chk("t1 msb word", d_out[0], 32'h0000_00B2);
        chk("t1 msb valid", {31'd0, d_ov[0]}, 32'd1);
        chk("t2 lsb word", d_out[1], 32'h0000_004D);
        step();
        chk("t1 valid one cycle", {31'd0, d_ov[0]}, 32'd0);

        // Bytes to word, then three words streamed back to back
        send_b(8'h11); send_b(8'h22); send_b(8'h33); send_b(8'h44);
        b_iv = 0;
        chk("t3 msb word", d_out[2], 32'h1122_3344);
        chk("t3 lsb word", d_out[3], 32'h4433_2211);
        chk("t3 depth1 word", d_out[4], 32'h0000_0044);
        for (int k = 1; k <= 12; k++) send_b(8'(k));
        b_iv = 0;
        chk("t3 stream last word", d_out[2], 32'h090A_0B0C);
        step();

        // Backpressure
        b_ordy = 0;
        send_b(8'hC1); send_b(8'hC2); send_b(8'hC3); send_b(8'hC4);
        send_b(8'hB1); send_b(8'hB2); send_b(8'hB3);
        b_iv = 1; b_in = 8'hB4;
        chk("t4 stall 4th beat", {31'd0, d_rdy[2]}, 32'd0);
        step(); step();
        chk("t4 held A", d_out[2], 32'hC1C2_C3C4);
        chk("t4 held valid", {31'd0, d_ov[2]}, 32'd1);
        b_ordy = 1;
        step();
        b_iv = 0;
        chk("t4 B loaded", d_out[2], 32'hB1B2_B3B4);
        chk("t4 B valid", {31'd0, d_ov[2]}, 32'd1);
        chk("t4 B lsb", d_out[3], 32'hB4B3_B2B1);
        step();
        chk("t4 B consumed", {31'd0, d_ov[2]}, 32'd0);

        // CLEAR mid-word with a word held
        b_ordy = 0;
        send_b(8'hD1); send_b(8'hD2); send_b(8'hD3); send_b(8'hD4);
        send_b(8'hE1); send_b(8'hE2);
        b_in = 8'hEE; b_iv = 1; b_clr = 1;
        step();
        b_clr = 0; b_iv = 0;
        chk("t5 partial cleared", {31'd0, d_part[2]}, 32'd0);
        chk("t5 held kept", d_out[2], 32'hD1D2_D3D4);
        b_ordy = 1;
        step();
        chk("t5 held delivered", {31'd0, d_ov[2]}, 32'd0);
        send_b(8'hA1); send_b(8'hA2); send_b(8'hA3); send_b(8'hA4);
        b_iv = 0;
        chk("t5 word after clear", d_out[2], 32'hA1A2_A3A4);
        step();

        // Asynchronous reset mid-word with a word held
        b_ordy = 0;
        send_b(8'h10); send_b(8'h20); send_b(8'h30); send_b(8'h40);
        send_b(8'h50); send_b(8'h60);
        b_iv = 0;
        #2 rstn = 0;
        #1;
        chk("t6 async valid", {31'd0, d_ov[2]}, 32'd0);
        chk("t6 async out", d_out[2], 32'd0);
        chk("t6 async partial", {31'd0, d_part[2]}, 32'd0);
        chk("t6 async ready", {31'd0, d_rdy[2]}, 32'd1);
        step(); step();
        #2 rstn = 1;
        b_ordy = 1;
        step();
        chk("t6 no word after release", {31'd0, d_ov[2]}, 32'd0);
        send_b(8'h71); send_b(8'h72); send_b(8'h73); send_b(8'h74);
        b_iv = 0;
        chk("t6 fresh word", d_out[2], 32'h7172_7374);
        step();
        chk("t6 single word", {31'd0, d_ov[2]}, 32'd0);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
